// File: rtl/pirdsp_simd_accum_if.sv
// Handshake and data bus between the SIMD multiplier array and the accumulate/reduce stage.
// The slave modport is the accumulator side; the master modport drives jobs and beats.
interface pirdsp_simd_accum_if #(
  parameter int PW    = 18,
  parameter int AW    = 24,
  parameter int LEN_W = 8
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [6*PW-1:0]   prod;
  logic              out_valid;
  logic              out_ready;
  logic [6*AW-1:0]   acc;
  logic [AW+2:0]     sum;
  logic [5:0]        ovf;
  logic              busy;

  modport slave (
    input  start, len, in_valid, prod, out_ready,
    output in_ready, out_valid, acc, sum, ovf, busy
  );

  modport master (
    output start, len, in_valid, prod, out_ready,
    input  in_ready, out_valid, acc, sum, ovf, busy
  );
endinterface

// File: rtl/pirdsp_simd_accum.sv
// Six-lane SIMD accumulate-and-reduce back end for the 9-bit multiplier array.
// Each lane wraps independently with a sticky overflow flag; a registered tree sums the lanes.
module pirdsp_simd_accum #(
  parameter int PW    = 18,
  parameter int AW    = 24,
  parameter int LEN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pirdsp_simd_accum_if.slave     bus
);

  // state    | meaning
  // S_IDLE   | waiting for start with nonzero len; results held
  // S_ACCUM  | accepting product beats until cnt runs out
  // S_REDUCE | adder tree result registered into sum
  // S_OUT    | results presented until out_ready
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_REDUCE, S_OUT} state_t;

  state_t                 state_q;
  logic [LEN_W-1:0]       cnt_q;
  logic signed [AW-1:0]   acc_q [6];
  logic signed [AW+2:0]   sum_q;
  logic [5:0]             ovf_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   busy_q;

  logic signed [AW-1:0]   ext_d [6];
  logic signed [AW-1:0]   add_d [6];
  logic [5:0]             lane_ovf_d;
  logic signed [AW+2:0]   lane_x [6];
  logic signed [AW+2:0]   pair_d [3];
  logic signed [AW+2:0]   sum_d;
  logic                   beat;

  assign beat = bus.in_valid & in_ready_q;

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      ext_d[i]      = {{(AW-PW){bus.prod[PW*i+PW-1]}}, bus.prod[PW*i +: PW]};
      add_d[i]      = acc_q[i] + ext_d[i];
      lane_ovf_d[i] = (acc_q[i][AW-1] == ext_d[i][AW-1]) &&
                      (add_d[i][AW-1] != acc_q[i][AW-1]);
      lane_x[i]     = {{3{acc_q[i][AW-1]}}, acc_q[i]};
    end
    // Three extra bits cover six signed addends exactly, so the tree never overflows.
    pair_d[0] = lane_x[0] + lane_x[1];
    pair_d[1] = lane_x[2] + lane_x[3];
    pair_d[2] = lane_x[4] + lane_x[5];
    sum_d     = pair_d[0] + pair_d[1] + pair_d[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sum_q       <= '0;
      ovf_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < 6; i++) acc_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && (bus.len != '0)) begin
            for (int i = 0; i < 6; i++) acc_q[i] <= '0;
            ovf_q      <= '0;
            cnt_q      <= bus.len;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (beat) begin
            for (int i = 0; i < 6; i++) acc_q[i] <= add_d[i];
            ovf_q <= ovf_q | lane_ovf_d;
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              in_ready_q <= 1'b0;
              state_q    <= S_REDUCE;
            end
          end
        end
        S_REDUCE: begin
          sum_q       <= sum_d;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < 6; g++) begin : g_lane_out
    assign bus.acc[AW*g +: AW] = acc_q[g];
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pirdsp_simd_accum.sv
// Directed bench for pirdsp_simd_accum: hand-computed lane and reduced results,
// latency, output stall, overflow, mid-job reset and zero-length start.
module tb_pirdsp_simd_accum;
  localparam int PW    = 18;
  localparam int AW    = 24;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pirdsp_simd_accum_if #(.PW(PW), .AW(AW), .LEN_W(LEN_W)) bus ();

  pirdsp_simd_accum #(.PW(PW), .AW(AW), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_lane(input string tag, input int i, input int v);
    logic [AW-1:0] e;
    e = AW'(v);
    chk(tag, 64'(bus.acc[AW*i +: AW]), 64'(e));
  endtask

  task automatic chk_all_lanes(input string tag, input int v);
    for (int i = 0; i < 6; i++) chk_lane(tag, i, v);
  endtask

  task automatic chk_sum(input string tag, input int v);
    logic [AW+2:0] e;
    e = (AW+3)'(v);
    chk(tag, 64'(bus.sum), 64'(e));
  endtask

  function automatic logic [6*PW-1:0] pack_all(input int v);
    logic [6*PW-1:0] p;
    for (int i = 0; i < 6; i++) p[PW*i +: PW] = PW'(v);
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a job, feeds n identical beats (optionally with a bubble before each),
  // and leaves the DUT in OUT with latency checked.
  task automatic run_job(input string tag, input int n, input logic [6*PW-1:0] p, input bit gaps);
    bus.start = 1'b1;
    bus.len   = LEN_W'(n);
    step();
    bus.start = 1'b0;
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(1));
    for (int b = 0; b < n; b++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        bus.prod     = (6*PW)'({$urandom, $urandom, $urandom, $urandom});
        step();
      end
      bus.in_valid = 1'b1;
      bus.prod     = p;
      step();
    end
    bus.in_valid = 1'b0;
    bus.prod     = (6*PW)'({$urandom, $urandom, $urandom, $urandom});
    chk({tag, "_reduce_ov"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_reduce_ir"}, 64'(bus.in_ready), 64'(0));
    step();
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6*PW-1:0] p1;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.prod      = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_acc", 64'(|bus.acc), 64'(0));
    chk("rst_sum", 64'(bus.sum), 64'(0));
    chk("rst_ovf", 64'(bus.ovf), 64'(0));
    step();
    step();
    rst_n = 1'b1;
    step();

    // Zero-length start is ignored
    bus.start = 1'b1;
    bus.len   = '0;
    step();
    bus.start = 1'b0;
    chk("zlen_busy", 64'(bus.busy), 64'(0));
    chk("zlen_in_ready", 64'(bus.in_ready), 64'(0));
    step();
    chk("zlen_busy2", 64'(bus.busy), 64'(0));

    // Single beat, lanes -3..2
    for (int i = 0; i < 6; i++) p1[PW*i +: PW] = PW'(i - 3);
    run_job("single", 1, p1, 1'b0);
    for (int i = 0; i < 6; i++) chk_lane("single_acc", i, i - 3);
    chk_sum("single_sum", -3);
    chk("single_ovf", 64'(bus.ovf), 64'(0));
    step();
    chk("single_idle_ov", 64'(bus.out_valid), 64'(0));
    chk("single_idle_busy", 64'(bus.busy), 64'(0));
    chk_lane("single_hold", 0, -3);
    chk_sum("single_hold_sum", -3);

    // Max products back-to-back, then with bubbles
    run_job("max", 4, pack_all(65536), 1'b0);
    chk_all_lanes("max_acc", 262144);
    chk_sum("max_sum", 1572864);
    chk("max_ovf", 64'(bus.ovf), 64'(0));
    step();
    run_job("maxgap", 4, pack_all(65536), 1'b1);
    chk_all_lanes("maxgap_acc", 262144);
    chk_sum("maxgap_sum", 1572864);
    step();

    // Overflow on every lane with the longest job
    run_job("ovf", 255, pack_all(65536), 1'b0);
    chk_all_lanes("ovf_acc", -65536);
    chk_sum("ovf_sum", -393216);
    chk("ovf_flags", 64'(bus.ovf), 64'h3F);
    step();
    run_job("ovfclr", 1, pack_all(3), 1'b0);
    chk("ovfclr_flags", 64'(bus.ovf), 64'(0));
    chk_all_lanes("ovfclr_acc", 3);
    chk_sum("ovfclr_sum", 18);
    step();

    // Output stall with start pulses that must be dropped
    bus.out_ready = 1'b0;
    run_job("stall", 2, pack_all(-7), 1'b0);
    for (int c = 0; c < 10; c++) begin
      bus.start = c[0];
      bus.len   = LEN_W'(3);
      step();
      chk("stall_ov", 64'(bus.out_valid), 64'(1));
      chk_lane("stall_acc", c % 6, -14);
      chk_sum("stall_sum", -84);
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("stall_release_ov", 64'(bus.out_valid), 64'(0));
    chk("stall_release_busy", 64'(bus.busy), 64'(0));
    step();
    chk("stall_not_queued", 64'(bus.busy), 64'(0));

    // Reset in the middle of a job
    bus.start = 1'b1;
    bus.len   = LEN_W'(8);
    step();
    bus.start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.in_valid = 1'b1;
      bus.prod     = pack_all(9);
      step();
    end
    chk_lane("mid_progress", 2, 27);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'(0));
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_acc", 64'(|bus.acc), 64'(0));
    chk("mid_rst_sum", 64'(bus.sum), 64'(0));
    chk("mid_rst_ovf", 64'(bus.ovf), 64'(0));
    step();
    rst_n = 1'b1;
    step();
    run_job("after_rst", 2, pack_all(5), 1'b0);
    chk_all_lanes("after_rst_acc", 10);
    chk_sum("after_rst_sum", 60);
    step();
    chk("after_rst_idle", 64'(bus.busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pirdsp_simd_accum.md
# pirdsp_simd_accum

Six-lane SIMD accumulate-and-reduce stage that sits directly downstream of the PIR-DSP 6×(9×9) signed multiplier array. It consumes the packed six-lane 18-bit product bus, one beat per handshake, and accumulates each lane independently for a programmed number of beats. It then reduces the six lane accumulators to one scalar sum and presents the per-lane and reduced results on a valid/ready output port. It is the dot-product / MAC back end for the 9-bit SIMD mode.

## Interface
- `PW`, 18, product width per lane (signed)
- `AW`, 24, accumulator width per lane (signed)
- `LEN_W`, 8, width of beat-count field
- `clk`  in  1  single clock, all logic rising-edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `start`  in  1  one-cycle request to begin a job; sampled only in IDLE
- `len`  in  LEN_W  beats per job, sampled with `start`
- `in_valid`  in  1  product beat valid
- `in_ready`  out  1  stage accepts a product beat
- `prod`  in  6*PW  packed products, lane i = `prod[PW*i +: PW]` (lane 0 = low multiplier slice)
- `out_valid`  out  1  results valid
- `out_ready`  in  1  downstream accepts results
- `acc`  out  6*AW  per-lane accumulators, lane i = `acc[AW*i +: AW]`
- `sum`  out  AW+3  signed sum of the six lanes
- `ovf`  out  6  per-lane sticky overflow flags for the current job
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCUM, REDUCE, OUT.
- **IDLE**
  - `in_ready`=0.
  - `start`=1 with `len`≠0: clear `acc` and `ovf`, load `cnt`=`len`, go to ACCUM.
  - `start` with `len`=0 is ignored; the state stays IDLE.
- **ACCUM**
  - `in_ready`=1.
  - On each beat (`in_valid`&`in_ready`): `acc_i` ← `acc_i` + sext(`prod_i`), and `cnt` decrements.
  - The beat accepted with `cnt`=1 moves the state to REDUCE.
- **REDUCE**
  - `in_ready`=0.
  - A registered adder tree computes `sum` = Σ sext(`acc_i`) to AW+3 bits; this is exact with no overflow.
  - Next state: OUT.
- **OUT**
  - `out_valid`=1; `acc`, `sum` and `ovf` are held stable.
  - The cycle with `out_valid`&`out_ready` returns the state to IDLE.
- **Lane arithmetic**
  - Two's-complement wrap modulo 2^AW.
  - `ovf_i` is set when an add of two same-sign operands yields an opposite-sign result.
  - `ovf` stays set until the next accepted `start`.
- **Ignored inputs**
  - `start` is ignored outside IDLE.
  - `prod` is ignored when `in_ready`=0.
- **Output hold**: `acc`, `sum` and `ovf` keep their last values in IDLE until the next accepted `start`.

## Timing
- **Reset** (`rst_n`=0, takes effect immediately): state=IDLE, `cnt`=0, `in_ready`=0, `out_valid`=0, `busy`=0, `acc`=0, `sum`=0, `ovf`=0.
- **Reset mid-job**: the job is abandoned with no output produced, and all outputs return to their reset values.
- **Start**: `start` accepted at edge t → `in_ready`=1 and `busy`=1 from cycle t+1.
- **Beat registration**: a beat accepted at edge t updates `acc` visibly at cycle t+1.
- **Latency**: last beat accepted at edge t → REDUCE during t+1 → `out_valid`=1 from cycle t+2.
  - Throughput: `len`+3 cycles minimum per job, with a zero-stall downstream.
- **Output stall**: if `out_ready` is held low, `out_valid` stays high and the state stays OUT indefinitely, with outputs stable.
- **Back-to-back jobs**: handshake at edge t → IDLE at t+1; a `start` at t+1 is accepted.
  - A `start` asserted during OUT is dropped, not queued.
- **Input bubbles**: gaps in `in_valid` during ACCUM stall the counter with no effect on `acc`.
- **Width extremes**: `len`=2^LEN_W−1 is legal; `cnt` never wraps.

## Test plan
- **Single beat**: `len`=1; lane i of `prod` = i−3 (−3..2).
  - Expect `acc` = {2,1,0,−1,−2,−3} (lane5..lane0), `sum`=−3, `ovf`=0.
  - `out_valid` is first seen 2 cycles after the beat.
- **Max products**: `len`=4; every lane = (−256)·(−256)=65536.
  - Expect each `acc`=262144, `sum`=1572864.
  - Repeat with `in_valid` toggling every other cycle and expect identical results.
- **Overflow**: `AW`=24, `len`=255; all lanes 65536.
  - Expect each `acc` = 255·65536 mod 2^24 = 16711680, read as −65536.
  - Expect `ovf`=6'h3F.
  - A following job with `len`=1 and small values clears `ovf` to 0.
- **Output stall**: hold `out_ready`=0 for 10 cycles in OUT.
  - `out_valid`, `acc` and `sum` must stay constant.
  - `start` pulses during the stall are ignored.
  - `out_ready`=1 → IDLE next cycle.
- **Reset mid-job**: assert `rst_n`=0 after 3 of 8 beats.
  - All outputs are 0 immediately.
  - After release, a new job with `len`=2 and all lanes 5 yields `acc`=10 per lane and `sum`=60.
- **Zero-length start**: `start` with `len`=0 → `busy` stays 0 and `in_ready` stays 0.
